// File: rtl/id_ex_operand_stage_if.sv
// rtl/id_ex_operand_stage_if.sv - ID/EX operand stage signal bundle
interface id_ex_operand_stage_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      id_valid;
   logic [DATA_WIDTH-1:0]     id_read_data_1;
   logic [DATA_WIDTH-1:0]     id_read_data_2;
   logic [DATA_WIDTH-1:0]     id_sign_ext_imm;
   logic [REG_ADDR_WIDTH-1:0] id_rs;
   logic [REG_ADDR_WIDTH-1:0] id_rt;
   logic [REG_ADDR_WIDTH-1:0] id_rd;
   logic [1:0]                id_alu_op;
   logic [5:0]                id_funct;
   logic                      id_alu_src;
   logic                      id_reg_dst;
   logic                      id_reg_write;
   logic                      id_mem_read;
   logic                      id_mem_write;
   logic                      id_mem_to_reg;
   logic                      id_branch;
   logic                      stall_in;
   logic                      flush_in;
   logic                      exmem_reg_write;
   logic [REG_ADDR_WIDTH-1:0] exmem_write_reg;
   logic [DATA_WIDTH-1:0]     exmem_alu_result;
   logic                      memwb_reg_write;
   logic [REG_ADDR_WIDTH-1:0] memwb_write_reg;
   logic [DATA_WIDTH-1:0]     memwb_write_data;
   logic                      load_use_stall;
   logic                      ex_valid;
   logic [DATA_WIDTH-1:0]     operand_a;
   logic [DATA_WIDTH-1:0]     operand_b;
   logic [3:0]                alu_control_signal;
   logic [DATA_WIDTH-1:0]     ex_store_data;
   logic [REG_ADDR_WIDTH-1:0] ex_write_reg;
   logic                      ex_reg_write;
   logic                      ex_mem_read;
   logic                      ex_mem_write;
   logic                      ex_mem_to_reg;
   logic                      ex_branch;

   modport master (
      output id_valid, id_read_data_1, id_read_data_2, id_sign_ext_imm,
             id_rs, id_rt, id_rd, id_alu_op, id_funct,
             id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
             id_mem_write, id_mem_to_reg, id_branch,
             stall_in, flush_in,
             exmem_reg_write, exmem_write_reg, exmem_alu_result,
             memwb_reg_write, memwb_write_reg, memwb_write_data,
      input  load_use_stall, ex_valid, operand_a, operand_b,
             alu_control_signal, ex_store_data, ex_write_reg,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch
   );

   modport slave (
      input  id_valid, id_read_data_1, id_read_data_2, id_sign_ext_imm,
             id_rs, id_rt, id_rd, id_alu_op, id_funct,
             id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
             id_mem_write, id_mem_to_reg, id_branch,
             stall_in, flush_in,
             exmem_reg_write, exmem_write_reg, exmem_alu_result,
             memwb_reg_write, memwb_write_reg, memwb_write_data,
      output load_use_stall, ex_valid, operand_a, operand_b,
             alu_control_signal, ex_store_data, ex_write_reg,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with ALU decode, forwarding and load-use bubbling
module id_ex_operand_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input logic                    clk,
   input logic                    rst_n,
   id_ex_operand_stage_if.slave   bus
);
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_NOP = 4'b1111;

   logic [3:0]                id_alu_control;
   logic                      load_use;
   logic                      ex_valid_q;
   logic                      ex_reg_write_q;
   logic                      ex_mem_read_q;
   logic                      ex_mem_write_q;
   logic                      ex_mem_to_reg_q;
   logic                      ex_branch_q;
   logic                      ex_alu_src_q;
   logic                      ex_reg_dst_q;
   logic [3:0]                ex_alu_control_q;
   logic [REG_ADDR_WIDTH-1:0] ex_rs_q;
   logic [REG_ADDR_WIDTH-1:0] ex_rt_q;
   logic [REG_ADDR_WIDTH-1:0] ex_rd_q;
   logic [DATA_WIDTH-1:0]     ex_read_data_1_q;
   logic [DATA_WIDTH-1:0]     ex_read_data_2_q;
   logic [DATA_WIDTH-1:0]     ex_imm_q;
   logic [DATA_WIDTH-1:0]     fwd_rs;
   logic [DATA_WIDTH-1:0]     fwd_rt;

   always_comb begin
      id_alu_control = ALU_NOP;
      case (bus.id_alu_op)
         2'b00: id_alu_control = ALU_ADD;
         2'b01: id_alu_control = ALU_SUB;
         2'b11: id_alu_control = ALU_OR;
         default: begin
            case (bus.id_funct)
               6'b100000: id_alu_control = ALU_ADD;
               6'b100010: id_alu_control = ALU_SUB;
               6'b100100: id_alu_control = ALU_AND;
               6'b100101: id_alu_control = ALU_OR;
               6'b101010: id_alu_control = ALU_SLT;
               6'b100111: id_alu_control = ALU_NOR;
               default:   id_alu_control = ALU_NOP;
            endcase
         end
      endcase
   end

   // A load in EX cannot forward its data in time for a dependent instruction in ID.
   assign load_use = bus.id_valid & ex_valid_q & ex_mem_read_q & (ex_rt_q != '0) &
                     ((ex_rt_q == bus.id_rs) | (ex_rt_q == bus.id_rt));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q       <= 1'b0;
         ex_reg_write_q   <= 1'b0;
         ex_mem_read_q    <= 1'b0;
         ex_mem_write_q   <= 1'b0;
         ex_mem_to_reg_q  <= 1'b0;
         ex_branch_q      <= 1'b0;
         ex_alu_src_q     <= 1'b0;
         ex_reg_dst_q     <= 1'b0;
         ex_alu_control_q <= 4'b0000;
         ex_rs_q          <= '0;
         ex_rt_q          <= '0;
         ex_rd_q          <= '0;
         ex_read_data_1_q <= '0;
         ex_read_data_2_q <= '0;
         ex_imm_q         <= '0;
      end else if (bus.flush_in || (!bus.stall_in && load_use)) begin
         // Bubble: only the control fields are cleared, data fields keep stale values.
         ex_valid_q       <= 1'b0;
         ex_reg_write_q   <= 1'b0;
         ex_mem_read_q    <= 1'b0;
         ex_mem_write_q   <= 1'b0;
         ex_mem_to_reg_q  <= 1'b0;
         ex_branch_q      <= 1'b0;
         ex_alu_src_q     <= 1'b0;
         ex_reg_dst_q     <= 1'b0;
         ex_alu_control_q <= ALU_ADD;
      end else if (!bus.stall_in) begin
         ex_valid_q       <= bus.id_valid;
         ex_reg_write_q   <= bus.id_valid & bus.id_reg_write;
         ex_mem_read_q    <= bus.id_valid & bus.id_mem_read;
         ex_mem_write_q   <= bus.id_valid & bus.id_mem_write;
         ex_mem_to_reg_q  <= bus.id_valid & bus.id_mem_to_reg;
         ex_branch_q      <= bus.id_valid & bus.id_branch;
         ex_alu_src_q     <= bus.id_valid & bus.id_alu_src;
         ex_reg_dst_q     <= bus.id_valid & bus.id_reg_dst;
         ex_alu_control_q <= id_alu_control;
         ex_rs_q          <= bus.id_rs;
         ex_rt_q          <= bus.id_rt;
         ex_rd_q          <= bus.id_rd;
         ex_read_data_1_q <= bus.id_read_data_1;
         ex_read_data_2_q <= bus.id_read_data_2;
         ex_imm_q         <= bus.id_sign_ext_imm;
      end
   end

   // EX/MEM is the younger result, so it overrides MEM/WB; $0 is never forwarded.
   always_comb begin
      fwd_rs = ex_read_data_1_q;
      if (bus.memwb_reg_write && (bus.memwb_write_reg != '0) && (bus.memwb_write_reg == ex_rs_q))
         fwd_rs = bus.memwb_write_data;
      if (bus.exmem_reg_write && (bus.exmem_write_reg != '0) && (bus.exmem_write_reg == ex_rs_q))
         fwd_rs = bus.exmem_alu_result;
   end

   always_comb begin
      fwd_rt = ex_read_data_2_q;
      if (bus.memwb_reg_write && (bus.memwb_write_reg != '0) && (bus.memwb_write_reg == ex_rt_q))
         fwd_rt = bus.memwb_write_data;
      if (bus.exmem_reg_write && (bus.exmem_write_reg != '0) && (bus.exmem_write_reg == ex_rt_q))
         fwd_rt = bus.exmem_alu_result;
   end

   assign bus.load_use_stall     = load_use;
   assign bus.ex_valid           = ex_valid_q;
   assign bus.operand_a          = fwd_rs;
   assign bus.operand_b          = ex_alu_src_q ? ex_imm_q : fwd_rt;
   assign bus.alu_control_signal = ex_alu_control_q;
   assign bus.ex_store_data      = fwd_rt;
   assign bus.ex_write_reg       = ex_reg_dst_q ? ex_rd_q : ex_rt_q;
   assign bus.ex_reg_write       = ex_reg_write_q;
   assign bus.ex_mem_read        = ex_mem_read_q;
   assign bus.ex_mem_write       = ex_mem_write_q;
   assign bus.ex_mem_to_reg      = ex_mem_to_reg_q;
   assign bus.ex_branch          = ex_branch_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - scoreboard bench for the ID/EX operand stage
module tb_id_ex_operand_stage;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   id_ex_operand_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

   id_ex_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [3:0]  alu;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  wr;
      logic        rw;
      logic        mr;
      bit          chk_data;
   } exp_t;

   exp_t sb[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic v, input logic [3:0] alu, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] wr, input logic rw,
                           input logic mr, input bit chk_data);
      exp_t e;
      e.v = v; e.alu = alu; e.a = a; e.b = b; e.wr = wr; e.rw = rw; e.mr = mr;
      e.chk_data = chk_data;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_check(input string tag);
      exp_t e;
      step();
      if (sb.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check_eq({tag, "_valid"}, 32'(bus.ex_valid), 32'(e.v));
         check_eq({tag, "_alu"}, 32'(bus.alu_control_signal), 32'(e.alu));
         check_eq({tag, "_reg_write"}, 32'(bus.ex_reg_write), 32'(e.rw));
         check_eq({tag, "_mem_read"}, 32'(bus.ex_mem_read), 32'(e.mr));
         if (e.chk_data) begin
            check_eq({tag, "_op_a"}, bus.operand_a, e.a);
            check_eq({tag, "_op_b"}, bus.operand_b, e.b);
            check_eq({tag, "_wr"}, 32'(bus.ex_write_reg), 32'(e.wr));
         end
      end
   endtask

   // ctl = {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch}
   task automatic id_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                           input logic [1:0] op, input logic [5:0] fn, input logic [6:0] ctl);
      bus.id_valid        = 1'b1;
      bus.id_rs           = rs;
      bus.id_rt           = rt;
      bus.id_rd           = rd;
      bus.id_read_data_1  = d1;
      bus.id_read_data_2  = d2;
      bus.id_sign_ext_imm = imm;
      bus.id_alu_op       = op;
      bus.id_funct        = fn;
      {bus.id_alu_src, bus.id_reg_dst, bus.id_reg_write, bus.id_mem_read,
       bus.id_mem_write, bus.id_mem_to_reg, bus.id_branch} = ctl;
   endtask

   task automatic clear_fwd();
      bus.exmem_reg_write  = 1'b0;
      bus.exmem_write_reg  = '0;
      bus.exmem_alu_result = '0;
      bus.memwb_reg_write  = 1'b0;
      bus.memwb_write_reg  = '0;
      bus.memwb_write_data = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   logic [5:0] fn_tab  [6];
   logic [3:0] alu_tab [6];

   initial begin
      n_cmp = 0;
      n_err = 0;
      fn_tab  = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000};
      alu_tab = '{4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b1100,   4'b1111};

      // reset with random inputs
      rst_n = 1'b0;
      id_instr(5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
               2'($urandom), 6'($urandom), 7'($urandom));
      bus.id_valid         = 1'b1;
      bus.stall_in         = 1'b0;
      bus.flush_in         = 1'b0;
      bus.exmem_reg_write  = 1'b1;
      bus.exmem_write_reg  = 5'($urandom);
      bus.exmem_alu_result = $urandom;
      bus.memwb_reg_write  = 1'b1;
      bus.memwb_write_reg  = 5'($urandom);
      bus.memwb_write_data = $urandom;
      repeat (3) step();
      check_eq("rst_valid", 32'(bus.ex_valid), 32'd0);
      check_eq("rst_alu", 32'(bus.alu_control_signal), 32'd0);
      check_eq("rst_op_a", bus.operand_a, 32'd0);
      check_eq("rst_op_b", bus.operand_b, 32'd0);
      check_eq("rst_lus", 32'(bus.load_use_stall), 32'd0);
      check_eq("rst_reg_write", 32'(bus.ex_reg_write), 32'd0);

      clear_fwd();
      bus.id_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // R-type add
      id_instr(5'd1, 5'd2, 5'd9, 32'd5, 32'd7, 32'd0, 2'b10, 6'b100000, 7'b0110000);
      push_exp(1'b1, 4'b0010, 32'd5, 32'd7, 5'd9, 1'b1, 1'b0, 1'b1);
      step_check("add");

      // or with rs=3, rt=5, then forwarding priority
      id_instr(5'd3, 5'd5, 5'd10, 32'h11, 32'h22, 32'd0, 2'b10, 6'b100101, 7'b0110000);
      push_exp(1'b1, 4'b0001, 32'h11, 32'h22, 5'd10, 1'b1, 1'b0, 1'b1);
      step_check("or");
      bus.exmem_reg_write = 1'b1; bus.exmem_write_reg = 5'd3; bus.exmem_alu_result = 32'hAA;
      bus.memwb_reg_write = 1'b1; bus.memwb_write_reg = 5'd3; bus.memwb_write_data = 32'hBB;
      #1 check_eq("fwd_exmem_prio", bus.operand_a, 32'hAA);
      bus.exmem_write_reg = 5'd0;
      #1 check_eq("fwd_memwb", bus.operand_a, 32'hBB);
      bus.memwb_write_reg = 5'd5;
      #1 check_eq("fwd_rt_store", bus.ex_store_data, 32'hBB);
      check_eq("fwd_rt_op_b", bus.operand_b, 32'hBB);
      check_eq("fwd_rs_none", bus.operand_a, 32'h11);
      bus.exmem_write_reg = 5'd5; bus.exmem_reg_write = 1'b0;
      #1 check_eq("fwd_exmem_no_wr", bus.ex_store_data, 32'hBB);
      clear_fwd();

      // lw $4 then dependent add
      id_instr(5'd1, 5'd4, 5'd0, 32'd100, 32'd0, 32'd8, 2'b00, 6'b000000, 7'b1011010);
      push_exp(1'b1, 4'b0010, 32'd100, 32'd8, 5'd4, 1'b1, 1'b1, 1'b1);
      step_check("lw");
      id_instr(5'd4, 5'd6, 5'd12, 32'h40, 32'h60, 32'd0, 2'b10, 6'b100000, 7'b0110000);
      #1 check_eq("lus_asserted", 32'(bus.load_use_stall), 32'd1);
      push_exp(1'b0, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      step_check("lus_bubble");
      check_eq("lus_released", 32'(bus.load_use_stall), 32'd0);
      push_exp(1'b1, 4'b0010, 32'h40, 32'h60, 5'd12, 1'b1, 1'b0, 1'b1);
      step_check("lus_reissue");

      // stall and flush together: flush wins
      bus.stall_in = 1'b1; bus.flush_in = 1'b1;
      push_exp(1'b0, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      step_check("stall_flush");
      bus.stall_in = 1'b0; bus.flush_in = 1'b0;
      id_instr(5'd7, 5'd8, 5'd13, 32'd50, 32'd20, 32'd0, 2'b01, 6'b000000, 7'b0010000);
      push_exp(1'b1, 4'b0110, 32'd50, 32'd20, 5'd8, 1'b1, 1'b0, 1'b1);
      step_check("sub");
      bus.stall_in = 1'b1;
      id_instr(5'd2, 5'd3, 5'd4, 32'd1, 32'd2, 32'd3, 2'b10, 6'b100111, 7'b0100000);
      for (int i = 0; i < 3; i++) begin
         push_exp(1'b1, 4'b0110, 32'd50, 32'd20, 5'd8, 1'b1, 1'b0, 1'b1);
         step_check($sformatf("stall%0d", i));
      end
      bus.stall_in = 1'b0;

      // addi with negative immediate
      id_instr(5'd2, 5'd10, 5'd0, 32'd3, 32'd99, 32'hFFFFFFFC, 2'b00, 6'b000000, 7'b1010000);
      push_exp(1'b1, 4'b0010, 32'd3, 32'hFFFFFFFC, 5'd10, 1'b1, 1'b0, 1'b1);
      step_check("addi");

      // funct table and ori-style class
      for (int i = 0; i < 6; i++) begin
         id_instr(5'(i + 1), 5'(i + 2), 5'(i + 20), 32'(i * 3), 32'(i * 5), 32'd0,
                  2'b10, fn_tab[i], 7'b0110000);
         push_exp(1'b1, alu_tab[i], 32'(i * 3), 32'(i * 5), 5'(i + 20), 1'b1, 1'b0, 1'b1);
         step_check($sformatf("funct%0d", i));
      end
      id_instr(5'd1, 5'd2, 5'd0, 32'd9, 32'd0, 32'h0F, 2'b11, 6'b000000, 7'b1010000);
      push_exp(1'b1, 4'b0001, 32'd9, 32'h0F, 5'd2, 1'b1, 1'b0, 1'b1);
      step_check("ori");

      // asynchronous reset between clock edges
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_valid", 32'(bus.ex_valid), 32'd0);
      check_eq("async_alu", 32'(bus.alu_control_signal), 32'd0);
      check_eq("async_op_a", bus.operand_a, 32'd0);
      check_eq("async_reg_write", 32'(bus.ex_reg_write), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      push_exp(1'b1, 4'b0001, 32'd9, 32'h0F, 5'd2, 1'b1, 1'b0, 1'b1);
      step_check("post_reset");
      check_eq("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage of the 5-stage MIPS-subset core; feeds the execute-stage ALU directly.
- Latches decoded instruction fields and controls, and registers the 4-bit ALU control code decoded from alu_op/funct.
- Selects forwarded operands from EX/MEM and MEM/WB to drive operand_a/operand_b.
- Detects load-use hazards, inserts bubbles, and honours stall/flush.

Parameters:
DATA_WIDTH, 32, datapath width
REG_ADDR_WIDTH, 5, register-index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_read_data_1  in  DATA_WIDTH  rs register-file value
id_read_data_2  in  DATA_WIDTH  rt register-file value
id_sign_ext_imm  in  DATA_WIDTH  sign-extended immediate
id_rs / id_rt / id_rd  in  REG_ADDR_WIDTH each  register indices
id_alu_op  in  2  main-decoder ALU op class
id_funct  in  6  instruction funct field
id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  decoded controls
stall_in  in  1  downstream stall: hold EX register
flush_in  in  1  branch-taken flush: kill EX register contents
exmem_reg_write  in  1  EX/MEM writes a register
exmem_write_reg  in  REG_ADDR_WIDTH  EX/MEM destination
exmem_alu_result  in  DATA_WIDTH  EX/MEM forward value
memwb_reg_write  in  1  MEM/WB writes a register
memwb_write_reg  in  REG_ADDR_WIDTH  MEM/WB destination
memwb_write_data  in  DATA_WIDTH  MEM/WB forward value
load_use_stall  out  1  freeze PC and IF/ID (combinational)
ex_valid  out  1  EX slot holds a real instruction
operand_a  out  DATA_WIDTH  ALU operand A
operand_b  out  DATA_WIDTH  ALU operand B
alu_control_signal  out  4  ALU operation code
ex_store_data  out  DATA_WIDTH  forwarded rt value for stores
ex_write_reg  out  REG_ADDR_WIDTH  destination (rd if reg_dst, else rt)
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered controls

Behaviour:
- Reset: all registered fields 0; ex_valid=0, alu_control_signal=4'b0000, all ex_* controls 0. Operands are then 0 (rs/rt=0, never forwarded).
- ALU decode (computed in ID, registered):
  - alu_op 00 -> 0010 (add)
  - alu_op 01 -> 0110 (sub)
  - alu_op 11 -> 0001 (or)
  - alu_op 10 -> by funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100; other funct -> 1111 (ALU returns 0).
- load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
- Register update priority, per rising edge:
  - flush_in: load bubble.
  - else stall_in: hold all fields.
  - else load_use_stall: load bubble.
  - else: load ID fields; ex_valid = id_valid.
- Bubble: ex_valid=0, every ex_* control 0, alu_control_signal=0010; data fields may retain values.
- Invalid ID (id_valid=0) loads with all controls forced 0.
- Forwarding (combinational from registered rs/rt; EX/MEM has priority over MEM/WB):
  - EX/MEM match: exmem_reg_write & exmem_write_reg != 0 & exmem_write_reg == ex_rs.
  - MEM/WB match: same rule using memwb_* signals.
  - No match: registered register-file value.
  - rt forwarding is identical and drives ex_store_data.
- operand_a = forwarded rs; operand_b = ex_alu_src ? ex_sign_ext_imm : forwarded rt.
- Register 0 is never forwarded; latency ID->operands is 1 cycle.
- Async reset mid-operation clears immediately, independent of clk; first load on the first edge after deassertion.

Test Plan:
- Reset asserted with random inputs -> ex_valid=0, alu_control_signal=0000, operand_a=operand_b=0, load_use_stall=0.
- R-type add (funct 100000, rs data 5, rt data 7, no hazards), one edge -> alu_control_signal=0010, operand_a=5, operand_b=7, ex_write_reg=rd.
- ex_rs=3, exmem (reg_write=1, reg 3, value 0xAA) and memwb (reg 3, value 0xBB) both matching -> operand_a=0xAA. Same with exmem_write_reg=0 -> 0xBB.
- lw to $4 in EX, then id_valid=1 with id_rs=4 -> load_use_stall=1; next edge ex_valid=0, ex_reg_write=0.
- stall_in=1 and flush_in=1 on the same edge with a valid ID instruction -> bubble loaded. stall_in=1 alone for 3 cycles -> EX fields unchanged.
- addi (alu_op 00, alu_src=1, imm 0xFFFFFFFC) -> alu_control_signal=0010, operand_b=0xFFFFFFFC. Unknown funct 000000 with alu_op 10 -> alu_control_signal=1111.
